riscv_multicycle_ctrl: RTL

//  Moore/Mealy control FSM that sequences the multicycle RISC-V datapath (PC, IR, MDR, A/B, ALUOut, unified memory).

---
 rtl/riscv_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Control FSM for a multicycle RV32 datapath (PC, IR, MDR, A/B, ALUOut, one
// shared memory). Decodes the IR fields, drives every datapath enable and mux
// select, and handshakes with the memory. Supports LW, SW, BEQ, ADDI, ADD/SUB.
// It also counts retired instructions and raises sticky halt/illegal flags.
//
// Ports
//   clk, reset (async, active-low)
//   opcode/funct3/funct7/instr_zero : IR fields, valid from DECODE onward
//   alu_zero                        : ALU result == 0 (BEQ outcome)
//   mem_ready                       : memory completes the current access
//   mem_req/mem_we/iord             : memory request, write enable, address select
//   ir_write/pc_write/pc_source     : IR load, PC load, PC input select
//   reg_write/mem_to_reg            : register write and writeback select
//   alu_src_a/alu_src_b/alu_op      : ALU operand selects and operation
//   state                           : current state (debug)
//   instret                         : retired-instruction count (wraps)
//   halted/illegal                  : sticky terminal-state flags
module riscv_multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 instr_zero,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_source,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_IMM_EXEC  = 4'd9,
        S_HALT      = 4'd10,
        S_ILLEGAL   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    state_t               state_reg, state_next;
    logic [INSTRET_W-1:0] instret_reg;
    logic                 halted_reg, illegal_reg;
    logic                 retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            instret_reg <= instret_reg + {{(INSTRET_W-1){1'b0}}, retire};
            halted_reg  <= halted_reg  | (state_reg == S_HALT);
            illegal_reg <= illegal_reg | (state_reg == S_ILLEGAL);
        end
    end

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;

        case (state_reg)
            S_FETCH: begin
                // PC <= PC + 4 and IR load happen only on the completing cycle
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut from the old PC
                alu_src_a = 2'b10;
                alu_src_b = 2'b11;
                if (instr_zero) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_next = S_MEM_ADDR;
                        OP_R:    state_next = (funct3 == 3'd0 && (funct7 == 7'h00 || funct7 == 7'h20))
                                              ? S_EXECUTE : S_ILLEGAL;
                        OP_BEQ:  state_next = (funct3 == 3'd0) ? S_BRANCH : S_ILLEGAL;
                        OP_ADDI: state_next = (funct3 == 3'd0) ? S_IMM_EXEC : S_ILLEGAL;
                        default: state_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALU_WB;
            end
            S_IMM_EXEC: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                // A - B; taken branch loads the target held in ALUOut
                alu_src_a  = 2'b01;
                alu_op     = 2'b01;
                pc_source  = 1'b1;
                pc_write   = alu_zero;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT, S_ILLEGAL: ;
            default: state_next = S_FETCH;
        endcase

        // Reset state is FETCH, which would otherwise request memory
        if (!reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_source  = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
        end
    end

    assign state   = state_reg;
    assign instret = instret_reg;
    assign halted  = halted_reg;
    assign illegal = illegal_reg;

endmodule
